instruction_sequencer: RTL and testbench

//  Fetch/decode/execute/writeback controller for the 8-bit soft CPU. Owns the instruction

---
 rtl/instruction_sequencer.sv | 167 ++++++++++++++++
 tb/tb_instruction_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute/writeback controller for the 8-bit soft CPU.
// One instruction in flight; four cycles per instruction when fetchAck is immediate.
module instruction_sequencer #(
    parameter int unsigned IP_WIDTH      = 17,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  run,
    output logic                  fetchReq,
    input  logic                  fetchAck,
    input  logic [25:0]           instruction,
    output logic [IP_WIDTH-1:0]   instructionPointer,
    output logic [3:0]            regReadAddrA,
    input  logic [DATA_WIDTH-1:0] regReadDataA,
    output logic [3:0]            regReadAddrB,
    input  logic [DATA_WIDTH-1:0] regReadDataB,
    output logic [3:0]            aluOp,
    output logic [DATA_WIDTH-1:0] aluOpA,
    output logic [DATA_WIDTH-1:0] aluOpB,
    input  logic [DATA_WIDTH-1:0] aluResult,
    output logic                  regWriteEn,
    output logic [3:0]            regWriteAddr,
    output logic [DATA_WIDTH-1:0] regWriteData,
    output logic                  retire,
    output logic                  illegalOp,
    output logic                  halted,
    output logic                  fetchError
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WRITEBACK, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_MOV  = 4'h5,
        OP_JMP  = 4'h6,
        OP_HALT = 4'hF
    } opcode_t;

    localparam int unsigned WAIT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);

    state_t                r_state;
    state_t                w_state_next;
    logic [IP_WIDTH-1:0]   r_ip;
    logic [IP_WIDTH-1:0]   w_ip_next;
    logic [25:0]           r_instr;
    logic [DATA_WIDTH-1:0] r_opA;
    logic [DATA_WIDTH-1:0] r_opB;
    logic [DATA_WIDTH-1:0] r_result;
    logic [WAIT_W-1:0]     r_wait;
    logic                  r_fetch_err;
    logic [3:0]            w_opcode;
    logic                  w_timeout;

    assign w_opcode = r_instr[25:22];
    // Counter holds the number of FETCH cycles already spent; an ack on the last allowed cycle wins.
    assign w_timeout = (FETCH_TIMEOUT != 0) && (r_wait == WAIT_LAST) && !fetchAck;

    assign instructionPointer = r_ip;
    assign regReadAddrA       = r_instr[16:13];
    assign regReadAddrB       = r_instr[7:4];
    assign fetchError         = r_fetch_err;

    always_comb begin
        w_state_next = r_state;
        w_ip_next    = r_ip;
        fetchReq     = 1'b0;
        aluOp        = '0;
        aluOpA       = '0;
        aluOpB       = '0;
        regWriteEn   = 1'b0;
        regWriteAddr = '0;
        regWriteData = '0;
        retire       = 1'b0;
        illegalOp    = 1'b0;
        halted       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                fetchReq = 1'b1;
                if (fetchAck) w_state_next = S_DECODE;
                else if (w_timeout) w_state_next = S_HALT;
            end
            S_DECODE: begin
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                aluOp        = w_opcode;
                aluOpA       = r_opA;
                aluOpB       = r_opB;
                w_state_next = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                retire       = 1'b1;
                w_ip_next    = r_ip + IP_WIDTH'(1);
                w_state_next = run ? S_FETCH : S_IDLE;
                case (w_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        regWriteEn   = 1'b1;
                        regWriteAddr = r_instr[3:0];
                        regWriteData = r_result;
                    end
                    OP_MOV: begin
                        regWriteEn   = 1'b1;
                        regWriteAddr = r_instr[3:0];
                        regWriteData = r_opA;
                    end
                    OP_NOP: ;
                    OP_JMP: begin
                        w_ip_next = r_instr[IP_WIDTH-1:0];
                    end
                    OP_HALT: begin
                        w_ip_next    = r_ip;
                        w_state_next = S_HALT;
                    end
                    default: begin
                        illegalOp = 1'b1;
                    end
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_ip        <= '0;
            r_instr     <= '0;
            r_opA       <= '0;
            r_opB       <= '0;
            r_result    <= '0;
            r_wait      <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ip    <= w_ip_next;
            r_wait  <= ((r_state == S_FETCH) && (w_state_next == S_FETCH)) ?
                       r_wait + WAIT_W'(1) : '0;
            if (r_state == S_FETCH) begin
                if (fetchAck) r_instr <= instruction;
                else if (w_timeout) r_fetch_err <= 1'b1;
            end
            if (r_state == S_DECODE) begin
                r_opA <= r_instr[21] ? regReadDataA : DATA_WIDTH'(r_instr[20:13]);
                r_opB <= r_instr[12] ? regReadDataB : DATA_WIDTH'(r_instr[11:4]);
            end
            if (r_state == S_EXEC) r_result <= aluResult;
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: directed vector table, randomized instructions scored
// against a reference model, and hand-written reset, run-drop, halt and timeout sequences.
module tb_instruction_sequencer;
    localparam int unsigned IPW = 17;
    localparam int unsigned TMO = 4;
    localparam logic [7:0] RF_INIT [16] = '{8'h10, 8'h21, 8'h32, 8'd200, 8'd100, 8'h55,
        8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hF0};

    logic           clock = 1'b0;
    logic           resetN;
    logic           run;
    logic           fetchReq;
    logic           fetchAck;
    logic [25:0]    instruction;
    logic [IPW-1:0] instructionPointer;
    logic [3:0]     regReadAddrA;
    logic [7:0]     regReadDataA;
    logic [3:0]     regReadAddrB;
    logic [7:0]     regReadDataB;
    logic [3:0]     aluOp;
    logic [7:0]     aluOpA;
    logic [7:0]     aluOpB;
    logic [7:0]     aluResult;
    logic           regWriteEn;
    logic [3:0]     regWriteAddr;
    logic [7:0]     regWriteData;
    logic           retire;
    logic           illegalOp;
    logic           halted;
    logic           fetchError;

    instruction_sequencer #(.IP_WIDTH(IPW), .DATA_WIDTH(8), .FETCH_TIMEOUT(TMO)) dut (
        .clock(clock), .resetN(resetN), .run(run),
        .fetchReq(fetchReq), .fetchAck(fetchAck), .instruction(instruction),
        .instructionPointer(instructionPointer),
        .regReadAddrA(regReadAddrA), .regReadDataA(regReadDataA),
        .regReadAddrB(regReadAddrB), .regReadDataB(regReadDataB),
        .aluOp(aluOp), .aluOpA(aluOpA), .aluOpB(aluOpB), .aluResult(aluResult),
        .regWriteEn(regWriteEn), .regWriteAddr(regWriteAddr), .regWriteData(regWriteData),
        .retire(retire), .illegalOp(illegalOp), .halted(halted), .fetchError(fetchError)
    );

    always #5 clock = ~clock;

    // External register file and ALU seen by the sequencer
    logic [7:0] rf [16] = RF_INIT;
    int         wr_count = 0;

    always_comb begin
        regReadDataA = rf[regReadAddrA];
        regReadDataB = rf[regReadAddrB];
    end

    always @(posedge clock) begin
        if (regWriteEn) begin
            rf[regWriteAddr] <= regWriteData;
            wr_count <= wr_count + 1;
        end
    end

    always_comb begin
        case (aluOp)
            4'h1:    aluResult = aluOpA + aluOpB;
            4'h2:    aluResult = aluOpA - aluOpB;
            4'h3:    aluResult = aluOpA & aluOpB;
            4'h4:    aluResult = aluOpA | aluOpB;
            default: aluResult = 8'h5A;
        endcase
    end

    typedef struct {
        string          name;
        logic [25:0]    ins;
        int unsigned    dly;
        logic [7:0]     a;
        logic [7:0]     b;
        bit             we;
        logic [3:0]     addr;
        logic [7:0]     data;
        bit             ill;
        logic [IPW-1:0] ip;
    } vec_t;

    vec_t        vecs [11];
    logic [7:0]  m_reg [16];
    int unsigned m_ip;
    int          exp_writes = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    endtask

    function automatic logic [25:0] mk(input logic [3:0] op, input logic f1, input logic [7:0] v1,
                                       input logic f2, input logic [7:0] v2, input logic [3:0] d);
        return {op, f1, v1, f2, v2, d};
    endfunction

    // Architectural meaning of one instruction given the current register and IP state
    function automatic vec_t model(input logic [25:0] ins, input int unsigned dly);
        vec_t        v;
        int unsigned a, b, r, op;
        op = 32'(ins[25:22]);
        a  = ins[21] ? 32'(m_reg[ins[16:13]]) : 32'(ins[20:13]);
        b  = ins[12] ? 32'(m_reg[ins[7:4]])   : 32'(ins[11:4]);
        case (op)
            1:       r = (a + b) % 256;
            2:       r = (a + 256 - b) % 256;
            3:       r = a & b;
            4:       r = a | b;
            default: r = a;
        endcase
        v.name = "rand";
        v.ins  = ins;
        v.dly  = dly;
        v.a    = 8'(a);
        v.b    = 8'(b);
        v.we   = (op >= 1) && (op <= 5);
        v.ill  = (op >= 7) && (op != 15);
        v.addr = ins[3:0];
        v.data = 8'(r);
        v.ip   = (op == 6) ? ins[IPW-1:0] : IPW'((m_ip + 1) % (32'd1 << IPW));
        return v;
    endfunction

    // Entered at a falling edge with the DUT in FETCH; leaves one cycle after WRITEBACK
    task automatic do_instr(input vec_t v, input bit run_during);
        for (int i = 0; i < int'(v.dly); i++) begin
            fetchAck    = 1'b0;
            instruction = 26'($urandom);
            check({v.name, " req_wait"}, 32'(fetchReq), 32'd1);
            @(negedge clock);
        end
        fetchAck    = 1'b1;
        instruction = v.ins;
        check({v.name, " req_ack"}, 32'(fetchReq), 32'd1);
        @(negedge clock);
        fetchAck    = 1'b0;
        instruction = 26'($urandom);
        run         = run_during;
        check({v.name, " req_drop"}, 32'(fetchReq), 32'd0);
        @(negedge clock);
        check({v.name, " aluOp"}, 32'(aluOp), 32'(v.ins[25:22]));
        check({v.name, " aluOpA"}, 32'(aluOpA), 32'(v.a));
        check({v.name, " aluOpB"}, 32'(aluOpB), 32'(v.b));
        @(negedge clock);
        check({v.name, " retire"}, 32'(retire), 32'(v.we ? 1 : 1));
        check({v.name, " wr_en"}, 32'(regWriteEn), 32'(v.we));
        check({v.name, " illegal"}, 32'(illegalOp), 32'(v.ill));
        if (v.we) begin
            check({v.name, " wr_addr"}, 32'(regWriteAddr), 32'(v.addr));
            check({v.name, " wr_data"}, 32'(regWriteData), 32'(v.data));
            m_reg[v.addr] = v.data;
            exp_writes++;
        end
        @(negedge clock);
        check({v.name, " ip"}, 32'(instructionPointer), 32'(v.ip));
        check({v.name, " next_req"}, 32'(fetchReq), 32'(run_during));
        check({v.name, " retire_pulse"}, 32'(retire), 32'd0);
        m_ip = 32'(v.ip);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " fetchReq"}, 32'(fetchReq), 32'd0);
        check({tag, " ip"}, 32'(instructionPointer), 32'd0);
        check({tag, " rdA"}, 32'(regReadAddrA), 32'd0);
        check({tag, " rdB"}, 32'(regReadAddrB), 32'd0);
        check({tag, " aluOp"}, 32'(aluOp), 32'd0);
        check({tag, " aluOpA"}, 32'(aluOpA), 32'd0);
        check({tag, " aluOpB"}, 32'(aluOpB), 32'd0);
        check({tag, " wr_en"}, 32'(regWriteEn), 32'd0);
        check({tag, " wr_addr"}, 32'(regWriteAddr), 32'd0);
        check({tag, " wr_data"}, 32'(regWriteData), 32'd0);
        check({tag, " retire"}, 32'(retire), 32'd0);
        check({tag, " illegal"}, 32'(illegalOp), 32'd0);
        check({tag, " halted"}, 32'(halted), 32'd0);
        check({tag, " fetchError"}, 32'(fetchError), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        logic [25:0] ins;
        resetN      = 1'b0;
        run         = 1'b0;
        fetchAck    = 1'b0;
        instruction = '0;
        m_ip        = 0;
        for (int i = 0; i < 16; i++) m_reg[i] = RF_INIT[i];

        vecs[0]  = '{"add_imm",  mk(4'h1, 1'b0, 8'd5,   1'b0, 8'd3,   4'd2),  0,
                     8'd5,   8'd3,   1'b1, 4'd2,  8'd8,   1'b0, 17'h00001};
        vecs[1]  = '{"add_reg",  mk(4'h1, 1'b1, 8'h03,  1'b1, 8'h04,  4'd7),  0,
                     8'd200, 8'd100, 1'b1, 4'd7,  8'd44,  1'b0, 17'h00002};
        vecs[2]  = '{"sub_wrap", mk(4'h2, 1'b0, 8'd3,   1'b0, 8'd5,   4'd1),  1,
                     8'd3,   8'd5,   1'b1, 4'd1,  8'hFE,  1'b0, 17'h00003};
        vecs[3]  = '{"and_dst0", mk(4'h3, 1'b1, 8'h03,  1'b0, 8'h0F,  4'd0),  0,
                     8'hC8,  8'h0F,  1'b1, 4'd0,  8'h08,  1'b0, 17'h00004};
        vecs[4]  = '{"or_mixed", mk(4'h4, 1'b0, 8'h50,  1'b1, 8'h04,  4'd15), 2,
                     8'h50,  8'h64,  1'b1, 4'd15, 8'h74,  1'b0, 17'h00005};
        vecs[5]  = '{"mov_imm",  mk(4'h5, 1'b0, 8'h99,  1'b0, 8'h00,  4'd5),  0,
                     8'h99,  8'h00,  1'b1, 4'd5,  8'h99,  1'b0, 17'h00006};
        vecs[6]  = '{"mov_reg",  mk(4'h5, 1'b1, 8'h02,  1'b0, 8'h00,  4'd6),  1,
                     8'h08,  8'h00,  1'b1, 4'd6,  8'h08,  1'b0, 17'h00007};
        vecs[7]  = '{"illegal",  mk(4'hA, 1'b0, 8'h01,  1'b0, 8'h02,  4'd3),  2,
                     8'h01,  8'h02,  1'b0, 4'd0,  8'h00,  1'b1, 17'h00008};
        vecs[8]  = '{"nop_late", mk(4'h0, 1'b0, 8'h07,  1'b0, 8'h09,  4'd4),  TMO - 1,
                     8'h07,  8'h09,  1'b0, 4'd0,  8'h00,  1'b0, 17'h00009};
        vecs[9]  = '{"jmp_top",  26'h181FFFF,                           0,
                     8'h0F,  8'h74,  1'b0, 4'd0,  8'h00,  1'b0, 17'h1FFFF};
        vecs[10] = '{"nop_wrap", mk(4'h0, 1'b0, 8'h00,  1'b0, 8'h00,  4'd0),  0,
                     8'h00,  8'h00,  1'b0, 4'd0,  8'h00,  1'b0, 17'h00000};

        repeat (3) @(negedge clock);
        check_zero("reset");
        resetN = 1'b1;
        run    = 1'b1;
        @(negedge clock);
        check("start_fetch", 32'(fetchReq), 32'd1);

        for (int i = 0; i < 11; i++) do_instr(vecs[i], 1'b1);
        check("no_fetch_err", 32'(fetchError), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ins = mk(4'($urandom_range(0, 14)), 1'($urandom), 8'($urandom),
                     1'($urandom), 8'($urandom), 4'($urandom));
            do_instr(model(ins, $urandom_range(0, TMO - 1)), 1'b1);
        end
        check("write_count", 32'(wr_count), 32'(exp_writes));

        // run dropped mid-instruction: it still retires, then idles with IP at the next address
        v = model(mk(4'h1, 1'b0, 8'h40, 1'b0, 8'h02, 4'd9), 0);
        v.name = "run_low";
        do_instr(v, 1'b0);
        repeat (3) begin
            @(negedge clock);
            check("idle_req", 32'(fetchReq), 32'd0);
            check("idle_ip", 32'(instructionPointer), 32'(m_ip));
        end
        run = 1'b1;
        @(negedge clock);
        check("resume_req", 32'(fetchReq), 32'd1);

        // Asynchronous reset while in EXEC
        fetchAck    = 1'b1;
        instruction = mk(4'h1, 1'b0, 8'h11, 1'b0, 8'h22, 4'd9);
        @(negedge clock);
        fetchAck = 1'b0;
        @(negedge clock);
        check("exec_aluop", 32'(aluOp), 32'd1);
        #2 resetN = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clock);
        @(negedge clock);
        check("reset_no_write", 32'(wr_count), 32'(exp_writes));
        resetN = 1'b1;
        m_ip   = 0;
        @(negedge clock);
        check("post_reset_req", 32'(fetchReq), 32'd1);

        // HALT opcode: no write, IP frozen, run ignored
        fetchAck    = 1'b1;
        instruction = mk(4'hF, 1'b0, 8'h12, 1'b0, 8'h34, 4'd3);
        @(negedge clock);
        fetchAck = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("halt_retire", 32'(retire), 32'd1);
        check("halt_no_wr", 32'(regWriteEn), 32'd0);
        check("halt_legal", 32'(illegalOp), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("halted", 32'(halted), 32'd1);
            check("halt_req", 32'(fetchReq), 32'd0);
            check("halt_ip", 32'(instructionPointer), 32'(m_ip));
            run = 1'(i % 2);
        end
        check("halt_write_count", 32'(wr_count), 32'(exp_writes));
        resetN = 1'b0;
        #1 check("unhalt", 32'(halted), 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        run    = 1'b1;
        m_ip   = 0;

        // Fetch timeout: request held TMO cycles, then sticky error and HALT
        @(negedge clock);
        for (int i = 0; i < int'(TMO); i++) begin
            check("tmo_req", 32'(fetchReq), 32'd1);
            check("tmo_err_early", 32'(fetchError), 32'd0);
            @(negedge clock);
        end
        check("tmo_err", 32'(fetchError), 32'd1);
        check("tmo_halted", 32'(halted), 32'd1);
        check("tmo_req_drop", 32'(fetchReq), 32'd0);
        @(negedge clock);
        check("tmo_sticky", 32'(fetchError), 32'd1);
        resetN = 1'b0;
        #1 check_zero("tmo_reset");
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
